// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - bus widths, alu_op bit indices and decode-to-execute bus layout
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 150;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_TO_ID_BUS_WD = 39;

    localparam int ALU_OP_WD = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 load_op;
        logic                 src1_is_pc;
        logic                 src2_is_imm;
        logic                 gr_we;
        logic                 mem_we;
        logic [4:0]           dest;
        logic [31:0]          imm;
        logic [31:0]          rj_value;
        logic [31:0]          rkd_value;
        logic [31:0]          pc;
    } ds_to_es_t;

endpackage

// File: rtl/exe_stage_alu.sv
// rtl/exe_stage_alu.sv - combinational ALU with a one-hot operation select
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          src1,
    input  logic [31:0]          src2,
    output logic [31:0]          result
);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;

    always_comb begin
        add_res  = src1 + src2;
        sub_res  = src1 - src2;
        slt_res  = {31'b0, $signed(src1) < $signed(src2)};
        sltu_res = {31'b0, src1 < src2};
        sll_res  = src1 << src2[4:0];
        srl_res  = src1 >> src2[4:0];
        sra_res  = $signed(src1) >>> src2[4:0];
        lui_res  = {src2[19:0], 12'b0};
    end

    // AND-OR select: an all-zero op vector naturally yields zero
    always_comb begin
        result = '0;
        result = result | ({32{alu_op[ALU_ADD]}}  & add_res);
        result = result | ({32{alu_op[ALU_SUB]}}  & sub_res);
        result = result | ({32{alu_op[ALU_SLT]}}  & slt_res);
        result = result | ({32{alu_op[ALU_SLTU]}} & sltu_res);
        result = result | ({32{alu_op[ALU_AND]}}  & (src1 & src2));
        result = result | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2));
        result = result | ({32{alu_op[ALU_OR]}}   & (src1 | src2));
        result = result | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2));
        result = result | ({32{alu_op[ALU_SLL]}}  & sll_res);
        result = result | ({32{alu_op[ALU_SRL]}}  & srl_res);
        result = result | ({32{alu_op[ALU_SRA]}}  & sra_res);
        result = result | ({32{alu_op[ALU_LUI]}}  & lui_res);
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: stage register, ALU, data SRAM request, bus packing
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_TO_ID_BUS_WD-1:0] es_to_id_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    logic      es_valid_q;
    logic      es_valid_d;
    ds_to_es_t ds_to_es_bus_q;
    ds_to_es_t ds_to_es_bus_d;
    logic      es_ready_go;
    logic      fire;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;

    always_comb begin
        es_ready_go    = 1'b1;
        es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
        es_to_ms_valid = es_valid_q && es_ready_go;
        es_valid_d     = es_allowin ? ds_to_es_valid : es_valid_q;
        ds_to_es_bus_d = (ds_to_es_valid && es_allowin) ? ds_to_es_t'(ds_to_es_bus)
                                                        : ds_to_es_bus_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
        end else begin
            es_valid_q <= es_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        ds_to_es_bus_q <= ds_to_es_bus_d;
    end

    always_comb begin
        src1 = ds_to_es_bus_q.src1_is_pc  ? ds_to_es_bus_q.pc  : ds_to_es_bus_q.rj_value;
        src2 = ds_to_es_bus_q.src2_is_imm ? ds_to_es_bus_q.imm : ds_to_es_bus_q.rkd_value;
    end

    exe_stage_alu u_alu (
        .alu_op (ds_to_es_bus_q.alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    // resetn gates the request so a store held across reset never reaches the SRAM edge
    always_comb begin
        fire            = es_valid_q && ms_allowin && resetn;
        data_sram_en    = fire && (ds_to_es_bus_q.load_op || ds_to_es_bus_q.mem_we);
        data_sram_we    = (fire && ds_to_es_bus_q.mem_we) ? 4'hf : 4'h0;
        data_sram_addr  = alu_result;
        data_sram_wdata = ds_to_es_bus_q.rkd_value;
    end

    always_comb begin
        es_to_ms_bus = {ds_to_es_bus_q.load_op, ds_to_es_bus_q.gr_we, ds_to_es_bus_q.dest,
                        alu_result, ds_to_es_bus_q.pc};
        es_to_id_bus = {es_valid_q && ds_to_es_bus_q.load_op, es_valid_q && ds_to_es_bus_q.gr_we,
                        ds_to_es_bus_q.dest, alu_result};
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

    logic         clk;
    logic         resetn;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [38:0]  es_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_to_id_bus    (es_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [149:0] mk(input int op_bit, input logic load, input logic s1pc,
                                        input logic s2imm, input logic gr_we, input logic mem_we,
                                        input logic [4:0] dest, input logic [31:0] imm,
                                        input logic [31:0] rj, input logic [31:0] rkd,
                                        input logic [31:0] pc);
        logic [11:0] op;
        op = (op_bit < 0) ? 12'h000 : (12'h001 << op_bit);
        return {op, load, s1pc, s2imm, gr_we, mem_we, dest, imm, rj, rkd, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic issue(input logic [149:0] b);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        tick();
        ds_to_es_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ms_allowin = 1'b1; ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 5'd0, 32'h8, 32'h1000, 32'h1, 32'h0);
        tick(); tick();
        chk("rst_es_to_ms_valid", {31'b0, es_to_ms_valid}, 32'd0);
        chk("rst_es_allowin", {31'b0, es_allowin}, 32'd1);
        chk("rst_sram_en", {31'b0, data_sram_en}, 32'd0);
        chk("rst_sram_we", {28'b0, data_sram_we}, 32'd0);
        chk("rst_es_ok", {31'b0, es_to_id_bus[37]}, 32'd0);
        chk("rst_es_data_from_mem", {31'b0, es_to_id_bus[38]}, 32'd0);
        ds_to_es_valid = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(mk(0, 0, 0, 0, 1, 0, 5'd5, 32'h0, 32'h7fffffff, 32'h1, 32'h1c000010));
        chk("add_valid", {31'b0, es_to_ms_valid}, 32'd1);
        chk("add_result", es_to_ms_bus[63:32], 32'h80000000);
        chk("add_ms_dest", {27'b0, es_to_ms_bus[68:64]}, 32'd5);
        chk("add_ms_gr_we", {31'b0, es_to_ms_bus[69]}, 32'd1);
        chk("add_ms_pc", es_to_ms_bus[31:0], 32'h1c000010);
        chk("add_es_ok", {31'b0, es_to_id_bus[37]}, 32'd1);
        chk("add_es_rf_dest", {27'b0, es_to_id_bus[36:32]}, 32'd5);
        chk("add_es_value", es_to_id_bus[31:0], 32'h80000000);
        chk("add_sram_en", {31'b0, data_sram_en}, 32'd0);
    endtask

    task automatic test_alu_ops();
        logic [149:0] vec [10];
        logic [31:0]  exp [10];
        vec[0] = mk(10, 0, 0, 1, 1, 0, 5'd2, 32'h4, 32'h80000000, 32'h0, 32'h0); exp[0] = 32'hf8000000;
        vec[1] = mk(3,  0, 0, 0, 1, 0, 5'd2, 32'h0, 32'h1, 32'hffffffff, 32'h0);  exp[1] = 32'h1;
        vec[2] = mk(2,  0, 0, 0, 1, 0, 5'd2, 32'h0, 32'h1, 32'hffffffff, 32'h0);  exp[2] = 32'h0;
        vec[3] = mk(11, 0, 0, 1, 1, 0, 5'd2, 32'h12345, 32'h0, 32'h0, 32'h0);     exp[3] = 32'h12345000;
        vec[4] = mk(1,  0, 0, 0, 1, 0, 5'd2, 32'h0, 32'h5, 32'h7, 32'h0);         exp[4] = 32'hfffffffe;
        vec[5] = mk(5,  0, 0, 0, 1, 0, 5'd2, 32'h0, 32'hf0f0f0f0, 32'h0f0f0f00, 32'h0); exp[5] = 32'h0000000f;
        vec[6] = mk(9,  0, 0, 0, 1, 0, 5'd2, 32'h0, 32'h80000000, 32'd31, 32'h0); exp[6] = 32'h1;
        vec[7] = mk(8,  0, 0, 1, 1, 0, 5'd2, 32'd31, 32'h1, 32'h0, 32'h0);        exp[7] = 32'h80000000;
        vec[8] = mk(7,  0, 0, 0, 1, 0, 5'd2, 32'h0, 32'hff00ff00, 32'h0ff00ff0, 32'h0); exp[8] = 32'hf0f0f0f0;
        vec[9] = mk(-1, 0, 0, 0, 1, 0, 5'd2, 32'h0, 32'h12345678, 32'h1, 32'h0);  exp[9] = 32'h0;
        for (int i = 0; i < 10; i++) begin
            issue(vec[i]);
            chk($sformatf("alu_vec%0d", i), es_to_ms_bus[63:32], exp[i]);
        end
    endtask

    task automatic test_bl();
        issue(mk(0, 0, 1, 1, 1, 0, 5'd1, 32'h4, 32'h0, 32'h0, 32'h1c000000));
        chk("bl_result", es_to_ms_bus[63:32], 32'h1c000004);
        chk("bl_dest", {27'b0, es_to_ms_bus[68:64]}, 32'd1);
    endtask

    task automatic test_store_stall();
        issue(mk(0, 0, 0, 1, 0, 1, 5'd0, 32'h8, 32'h1000, 32'hdeadbeef, 32'h0));
        ms_allowin = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 5'd0, 32'h40, 32'h5000, 32'h11111111, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_we", c), {28'b0, data_sram_we}, 32'h0);
            chk($sformatf("stall%0d_en", c), {31'b0, data_sram_en}, 32'h0);
            chk($sformatf("stall%0d_allowin", c), {31'b0, es_allowin}, 32'h0);
            chk($sformatf("stall%0d_addr", c), data_sram_addr, 32'h1008);
            tick();
        end
        ds_to_es_valid = 1'b0;
        ms_allowin = 1'b1;
        #1;
        chk("release_we", {28'b0, data_sram_we}, 32'hf);
        chk("release_en", {31'b0, data_sram_en}, 32'h1);
        chk("release_addr", data_sram_addr, 32'h1008);
        chk("release_wdata", data_sram_wdata, 32'hdeadbeef);
        tick();
        chk("after_store_we", {28'b0, data_sram_we}, 32'h0);
        chk("after_store_valid", {31'b0, es_to_ms_valid}, 32'h0);
    endtask

    task automatic test_load();
        issue(mk(0, 1, 0, 1, 1, 0, 5'd7, 32'h10, 32'h2000, 32'h0, 32'h0));
        chk("ld_data_from_mem", {31'b0, es_to_id_bus[38]}, 32'd1);
        chk("ld_sram_en", {31'b0, data_sram_en}, 32'd1);
        chk("ld_sram_we", {28'b0, data_sram_we}, 32'd0);
        chk("ld_res_from_mem", {31'b0, es_to_ms_bus[70]}, 32'd1);
        chk("ld_addr", data_sram_addr, 32'h2010);
    endtask

    task automatic test_reset_mid();
        issue(mk(0, 0, 0, 1, 0, 1, 5'd0, 32'h4, 32'h3000, 32'hcafef00d, 32'h0));
        ms_allowin = 1'b0;
        tick();
        resetn = 1'b0;
        ms_allowin = 1'b1;
        #1;
        chk("rstmid_we", {28'b0, data_sram_we}, 32'h0);
        chk("rstmid_en", {31'b0, data_sram_en}, 32'h0);
        tick();
        chk("rstmid_valid", {31'b0, es_to_ms_valid}, 32'h0);
        chk("rstmid_allowin", {31'b0, es_allowin}, 32'h1);
        resetn = 1'b1;
        tick();
        chk("rstmid_after_we", {28'b0, data_sram_we}, 32'h0);
    endtask

    task automatic test_back_to_back();
        ms_allowin = 1'b1;
        ds_to_es_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ds_to_es_bus = mk(0, 0, 0, 0, 1, 0, 5'(i + 10), 32'h0, 32'(i * 16), 32'd100, 32'h0);
            tick();
            chk($sformatf("b2b%0d_valid", i), {31'b0, es_to_ms_valid}, 32'd1);
            chk($sformatf("b2b%0d_result", i), es_to_ms_bus[63:32], 32'(i * 16 + 100));
            chk($sformatf("b2b%0d_dest", i), {27'b0, es_to_id_bus[36:32]}, 32'(i + 10));
        end
        ds_to_es_valid = 1'b0;
        tick();
        chk("bubble_valid", {31'b0, es_to_ms_valid}, 32'd0);
        chk("bubble_es_ok", {31'b0, es_to_id_bus[37]}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        ms_allowin = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus = '0;
        test_reset();
        test_add();
        test_alu_ops();
        test_bl();
        test_store_stall();
        test_load();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
